// File: rtl/layer1_dense_mac.sv
// Second dense layer of the fixed-point MLP: one time-shared signed MAC, N_IN*N_OUT cycles per run.
// Define LAYER1_SAT_EN to saturate (instead of wrap) the WIDTH-bit reduction before the activation.
module layer1_dense_mac #(
    parameter int N_IN     = 2,
    parameter int N_OUT    = 2,
    parameter int WIDTH    = 8,
    parameter int FRAC     = 4,
    parameter int ACT_RELU = 1,
    localparam int AW      = $clog2(N_IN*N_OUT + N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [N_IN*WIDTH-1:0]  in_vec,
    input  logic                   w_we,
    input  logic [AW-1:0]          w_addr,
    input  logic [WIDTH-1:0]       w_data,
    output logic                   busy,
    output logic                   ack,
    output logic [N_OUT*WIDTH-1:0] out_vec
);

    localparam int NW    = N_IN * N_OUT;
    localparam int PW    = 2 * WIDTH;
    localparam int ACC_W = PW + $clog2(N_IN) + 1;
    localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int WIW   = (NW    > 1) ? $clog2(NW)    : 1;

    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((1 << (WIDTH-1)) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN = -S_MAX - ACC_W'(1);
    localparam logic signed [WIDTH-1:0] ONE   = WIDTH'(1 << FRAC);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } state_t;

    state_t                   state;
    logic [IW-1:0]            i;
    logic [JW-1:0]            j;
    logic [WIW-1:0]           widx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [WIDTH-1:0]  a [N_IN];
    logic signed [WIDTH-1:0]  w [NW];
    logic signed [WIDTH-1:0]  b [N_OUT];

    logic signed [WIDTH-1:0]  a_cur;
    logic signed [WIDTH-1:0]  w_cur;
    logic signed [WIDTH-1:0]  b_cur;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     prod_sh;
    logic signed [ACC_W-1:0]  acc_n;
    logic signed [ACC_W-1:0]  s;
    logic signed [WIDTH-1:0]  red;
    logic signed [WIDTH-1:0]  res;

    // widx walks the flattened w[j][i] index alongside (j,i), avoiding a j*N_IN+i multiply
    always_comb begin
        a_cur   = a[i];
        w_cur   = w[widx];
        b_cur   = b[j];
        prod    = a_cur * w_cur;
        prod_sh = prod >>> FRAC;
        acc_n   = acc + {{(ACC_W-PW){prod_sh[PW-1]}}, prod_sh};
        s       = acc_n + {{(ACC_W-WIDTH){b_cur[WIDTH-1]}}, b_cur};
    end

`ifdef LAYER1_SAT_EN
    always_comb begin
        if (s > S_MAX) begin
            red = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (s < S_MIN) begin
            red = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            red = s[WIDTH-1:0];
        end
    end
`else
    logic s_hi_unused;
    assign s_hi_unused = ^{s[ACC_W-1:WIDTH], S_MAX, S_MIN};
    always_comb begin
        red = s[WIDTH-1:0];
    end
`endif

    always_comb begin
        res = red;
        if (ACT_RELU != 0 && red[WIDTH-1]) begin
            res = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            ack     <= 1'b0;
            out_vec <= '0;
            i       <= '0;
            j       <= '0;
            widx    <= '0;
            acc     <= '0;
            for (int unsigned k = 0; k < N_IN; k++) begin
                a[k] <= '0;
            end
            for (int unsigned k = 0; k < NW; k++) begin
                w[k] <= ONE;
            end
            for (int unsigned k = 0; k < N_OUT; k++) begin
                b[k] <= ONE;
            end
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (w_we) begin
                        for (int unsigned k = 0; k < NW; k++) begin
                            if (w_addr == AW'(k)) begin
                                w[k] <= w_data;
                            end
                        end
                        for (int unsigned k = 0; k < N_OUT; k++) begin
                            if (w_addr == AW'(NW + k)) begin
                                b[k] <= w_data;
                            end
                        end
                    end
                    if (req) begin
                        for (int unsigned k = 0; k < N_IN; k++) begin
                            a[k] <= in_vec[k*WIDTH +: WIDTH];
                        end
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                        widx  <= '0;
                        busy  <= 1'b1;
                        state <= MAC;
                    end
                end
                MAC: begin
                    widx <= widx + WIW'(1);
                    if (i == IW'(N_IN - 1)) begin
                        for (int unsigned k = 0; k < N_OUT; k++) begin
                            if (j == JW'(k)) begin
                                out_vec[k*WIDTH +: WIDTH] <= res;
                            end
                        end
                        acc <= '0;
                        i   <= '0;
                        j   <= j + JW'(1);
                        if (j == JW'(N_OUT - 1)) begin
                            state <= DONE;
                        end
                    end else begin
                        acc <= acc_n;
                        i   <= i + IW'(1);
                    end
                end
                DONE: begin
                    ack   <= 1'b1;
                    busy  <= 1'b0;
                    i     <= '0;
                    j     <= '0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer1_dense_mac.sv
// Scoreboard bench for layer1_dense_mac: runs push expected out_vec, an ack monitor pops and compares.
module tb_layer1_dense_mac;

    logic        clk;
    logic        rst;
    logic        req;
    logic [15:0] in_vec;
    logic        w_we;
    logic [2:0]  w_addr;
    logic [7:0]  w_data;
    logic        busy;
    logic        ack;
    logic [15:0] out_vec;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q [$];

    layer1_dense_mac #(
        .N_IN(2),
        .N_OUT(2),
        .WIDTH(8),
        .FRAC(4),
        .ACT_RELU(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .in_vec(in_vec),
        .w_we(w_we),
        .w_addr(w_addr),
        .w_data(w_data),
        .busy(busy),
        .ack(ack),
        .out_vec(out_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack consumes one expected result
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ack: got ack with out_vec %0h, expected no ack", out_vec);
            end else begin
                check("out_vec", {16'h0, out_vec}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        w_we = 1'b1; w_addr = addr; w_data = data;
        @(posedge clk); #1;
        w_we = 1'b0;
    endtask

    task automatic run(input logic [15:0] vin, input logic [15:0] exp);
        int cyc;
        in_vec = vin;
        req = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        req = 1'b0;
        check("busy_start", {31'h0, busy}, 32'd1);
        cyc = 0;
        while (ack !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, 32'd5);
        @(posedge clk); #1;
        check("busy_end", {31'h0, busy}, 32'd0);
    endtask

    initial begin
        int ack_at [$];
        rst = 1'b0; req = 1'b0; in_vec = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
        #2;
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_ack", {31'h0, ack}, 32'd0);
        check("rst_out", {16'h0, out_vec}, 32'd0);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        // 1: default params, a={32,48} -> 32+48+16 = 96 per output
        run({8'd48, 8'd32}, {8'd96, 8'd96});
        // 2: negative sum -64 -> ReLU -> 0
        run({8'hD0, 8'hE0}, 16'h0000);
        // 3: w[0][1] = -16 -> out0 = 32-48+16 = 0
        wr(3'd1, 8'hF0);
        run({8'd48, 8'd32}, {8'd96, 8'd0});
        wr(3'd1, 8'd16);
        // 4: overflow, s = 2032
        for (int k = 0; k < 4; k++) wr(3'(k), 8'd127);
        `ifdef LAYER1_SAT_EN
        run({8'd127, 8'd127}, 16'h7F7F);
        `else
        run({8'd127, 8'd127}, 16'h0000);
        `endif
        for (int k = 0; k < 4; k++) wr(3'(k), 8'd16);
        // bias write b[1]=32 -> out1 = 112; out-of-range addrs ignored
        wr(3'd5, 8'd32);
        wr(3'd6, 8'h80);
        wr(3'd7, 8'h80);
        run({8'd48, 8'd32}, {8'd112, 8'd96});
        wr(3'd5, 8'd16);

        // 5: req held 12 cycles -> two runs, ack every 6; w_we while busy ignored
        in_vec = {8'd48, 8'd32};
        req = 1'b1;
        exp_q.push_back({8'd96, 8'd96});
        exp_q.push_back({8'd96, 8'd96});
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) ack_at.push_back(c);
            if (c == 2) begin w_we = 1'b1; w_addr = 3'd0; w_data = 8'd0; end
            if (c == 3) w_we = 1'b0;
        end
        req = 1'b0;
        check("ack_count", ack_at.size(), 32'd2);
        if (ack_at.size() == 2) begin
            check("ack_first", ack_at[0], 32'd5);
            check("ack_period", ack_at[1] - ack_at[0], 32'd6);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;

        // 6: reset mid-run restores defaults; a pre-run write proves it
        wr(3'd0, 8'd0);
        in_vec = {8'd48, 8'd32};
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_busy", {31'h0, busy}, 32'd0);
        check("midrst_ack", {31'h0, ack}, 32'd0);
        check("midrst_out", {16'h0, out_vec}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) @(posedge clk);
        #1;
        run({8'd48, 8'd32}, {8'd96, 8'd96});

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
